// File: rtl/md_pad_responder.sv
// -----------------------------------------------------------------------------
// md_pad_responder
//
// Emulates the pad side of a Mega Drive style controller port. The host toggles
// the select line. Each toggle advances a small edge counter, and the counter
// together with the select level chooses which buttons appear on the six data
// lines. After a long quiet spell on select, the counter falls back to zero so
// that the host can start a new read sequence.
//
// Configuration macro:
//   MD_SIX_BUTTON_EN  defined   -> 6-button pad. The 3rd low phase, the extra
//                                  button phase and the 4th low phase are
//                                  decoded.
//                     undefined -> 3-button pad. Only the normal high and low
//                                  maps are used, and X/Y/Z/Mode are ignored.
//                                  The edge counter and the idle timer still
//                                  run.
//
// Parameters:
//   TIMEOUT_CYC  Number of select-idle clk_sys cycles after which the edge
//                counter returns to 0 (default 60000 = 1.5 ms at 40 MHz).
//
// Ports:
//   clk_sys   in   1   System clock. All logic runs on its rising edge.
//   reset     in   1   Synchronous, active-high reset.
//   sel_in    in   1   Asynchronous select line from the host. Idles high.
//   btn       in  12   Active-high buttons {Mode,X,Y,Z,Start,A,C,B,U,D,L,R}.
//   pad_out   out  6   Active-low data lines D5..D0, registered.
//   phase     out  4   Current edge-counter value, for debug.
// -----------------------------------------------------------------------------
module md_pad_responder #(
   parameter int TIMEOUT_CYC = 60000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        sel_in,
   input  logic [11:0] btn,
   output logic [5:0]  pad_out,
   output logic [3:0]  phase
);

   // The timer never holds a value above TIMEOUT_CYC-2, so clog2 bits suffice.
   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   // The timeout fires on the clock edge where the timer would step to
   // TIMEOUT_CYC-1. At that edge it clears instead of counting.
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 2);
   localparam logic [3:0]    E_MAX      = 4'd8;

   typedef enum logic [2:0] {
      MAP_HIGH,      // sel high: C B R L D U
      MAP_LOW,       // sel low: Start A 0 0 D U
      MAP_LOW_ZERO,  // 3rd low phase: Start A 0000
      MAP_EXTRA,     // extra-button phase: C B Mode X Y Z
      MAP_LOW_ONES   // 4th low phase: Start A 1111
   } map_t;

   // Button aliases for the 3-button set.
   logic b_start, b_a, b_c, b_b, b_u, b_d, b_l, b_r;
   assign b_start = btn[7];
   assign b_a     = btn[6];
   assign b_c     = btn[5];
   assign b_b     = btn[4];
   assign b_u     = btn[3];
   assign b_d     = btn[2];
   assign b_l     = btn[1];
   assign b_r     = btn[0];

`ifdef MD_SIX_BUTTON_EN
   localparam logic [3:0] E_LOW3  = 4'd5;
   localparam logic [3:0] E_EXTRA = 4'd6;
   localparam logic [3:0] E_LOW4  = 4'd7;

   logic b_mode, b_x, b_y, b_z;
   assign b_mode = btn[11];
   assign b_x    = btn[10];
   assign b_y    = btn[9];
   assign b_z    = btn[8];
`else
   // The 3-button pad has no use for the extra buttons.
   logic unused_extra_btn;
   assign unused_extra_btn = ^btn[11:8];
`endif

   logic          sel_meta;
   logic          sel_s;
   logic          sel_prev;
   logic          sel_edge;
   logic [3:0]    e_q;
   logic [3:0]    e_d;
   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;
   map_t          map_sel;
   logic [5:0]    pad_d;

   // ------------------------------------------------------------------------
   // Select synchronizer and edge detect.
   // sel_prev also resets high, so leaving reset never shows a false edge.
   // ------------------------------------------------------------------------
   // NOTE: reset is sampled on the clock edge, so it lives inside the clocked
   // branch and is absent from the sensitivity list.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         // NOTE: sequential state uses <= so every flop samples the values
         // from before the edge. With = the three flops would collapse.
         sel_meta <= 1'b1;
         sel_s    <= 1'b1;
         sel_prev <= 1'b1;
      end else begin
         sel_meta <= sel_in;
         sel_s    <= sel_meta;
         sel_prev <= sel_s;
      end
   end

   assign sel_edge = sel_s ^ sel_prev;

   // ------------------------------------------------------------------------
   // Edge counter and idle timer. An edge always wins over a timeout in the
   // same cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: defaults come first so every path assigns every output. A
      // missing default would infer a latch.
      e_d     = e_q;
      timer_d = timer_q + 1'b1;
      if (sel_edge) begin
         timer_d = '0;
         if (e_q != E_MAX) begin
            e_d = e_q + 1'b1;
         end
      end else if (timer_q == TIMER_LAST) begin
         timer_d = '0;
         e_d     = '0;
      end
   end

   // ------------------------------------------------------------------------
   // Map selection. It uses the next counter value so that the edge update
   // and the new pad data land on the same clock edge. Latency is then
   // 2 synchronizer flops plus the output register.
   // ------------------------------------------------------------------------
   always_comb begin
      map_sel = MAP_LOW;
      if (sel_s) begin
         map_sel = MAP_HIGH;
      end
`ifdef MD_SIX_BUTTON_EN
      // A level that does not match the expected parity keeps the normal map.
      if (!sel_s && e_d == E_LOW3) begin
         map_sel = MAP_LOW_ZERO;
      end else if (sel_s && e_d == E_EXTRA) begin
         map_sel = MAP_EXTRA;
      end else if (!sel_s && e_d == E_LOW4) begin
         map_sel = MAP_LOW_ONES;
      end
`endif
   end

   always_comb begin
      pad_d = 6'b111111;
      case (map_sel)
         MAP_HIGH:     pad_d = ~{b_c, b_b, b_r, b_l, b_d, b_u};
         MAP_LOW:      pad_d = {~b_start, ~b_a, 2'b00, ~b_d, ~b_u};
`ifdef MD_SIX_BUTTON_EN
         MAP_LOW_ZERO: pad_d = {~b_start, ~b_a, 4'b0000};
         MAP_EXTRA:    pad_d = ~{b_c, b_b, b_mode, b_x, b_y, b_z};
         MAP_LOW_ONES: pad_d = {~b_start, ~b_a, 4'b1111};
`endif
         default:      pad_d = 6'b111111;
      endcase
   end

   // ------------------------------------------------------------------------
   // State and output registers. Buttons are sampled every cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         pad_out <= 6'b111111;
         e_q     <= '0;
         timer_q <= '0;
      end else begin
         pad_out <= pad_d;
         e_q     <= e_d;
         timer_q <= timer_d;
      end
   end

   assign phase = e_q;

endmodule

// File: tb/tb_md_pad_responder.sv
// -----------------------------------------------------------------------------
// tb_md_pad_responder
//
// Scoreboard bench for md_pad_responder. The stimulus pushes each expected
// (pad_out, phase) pair, tagged with the cycle where it is due. A monitor
// thread compares the DUT outputs on every falling edge.
// The expected tables follow MD_SIX_BUTTON_EN, the same macro the RTL uses.
// -----------------------------------------------------------------------------
module tb_md_pad_responder;

  localparam int T = 40;  // short timeout keeps the run brief

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        sel_in  = 1'b1;
  logic [11:0] btn     = '0;
  logic [5:0]  pad_out;
  logic [3:0]  phase;

  md_pad_responder #(.TIMEOUT_CYC(T)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .sel_in  (sel_in),
    .btn     (btn),
    .pad_out (pad_out),
    .phase   (phase)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [5:0] pad;
    logic [3:0] ph;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [5:0]  seq_pad [0:7];
  logic [11:0] seq_btn;

  task automatic check(input string nm, input logic [5:0] pad_act, input logic [3:0] ph_act,
                       input logic [5:0] pad_exp, input logic [3:0] ph_exp);
    checks++;
    if (pad_act !== pad_exp || ph_act !== ph_exp) begin
      errors++;
      $display("FAIL %s: got pad_out=%b phase=%0d, expected pad_out=%b phase=%0d",
               nm, pad_act, ph_act, pad_exp, ph_exp);
    end
  endtask

  // Queue an expectation d cycles after the current cycle.
  function automatic void expect_in(input int d, input logic [5:0] p, input logic [3:0] ph,
                                    input string nm);
    exp_t e;
    e.at  = cyc + d;
    e.pad = p;
    e.ph  = ph;
    e.nm  = nm;
    sb.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  exp_t cur;

  initial begin
`ifdef MD_SIX_BUTTON_EN
    seq_btn = 12'h800;
    seq_pad = '{6'b111111, 6'b110011, 6'b111111, 6'b110011,
                6'b111111, 6'b110000, 6'b110111, 6'b111111};
`else
    seq_btn = 12'hF00;
    seq_pad = '{6'b111111, 6'b110011, 6'b111111, 6'b110011,
                6'b111111, 6'b110011, 6'b111111, 6'b110011};
`endif

    // Monitor: compares every queued expectation in its due cycle.
    fork
      forever begin
        @(negedge clk_sys);
        while (sb.size() > 0 && sb[0].at < cyc) begin
          cur = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL %s: due at cycle %0d, never compared (now %0d)", cur.nm, cur.at, cyc);
        end
        while (sb.size() > 0 && sb[0].at == cyc) begin
          cur = sb.pop_front();
          check(cur.nm, pad_out, phase, cur.pad, cur.ph);
        end
      end
    join_none

    // Reset overrides a pressed button.
    btn = 12'h001;
    tick(1);
    expect_in(1, 6'b111111, 4'd0, "reset_hold");
    tick(2);

    // Release reset: the normal high map applies at once. R sits on D3.
    reset = 1'b0;
    expect_in(1, 6'b110111, 4'd0, "post_reset_high_map");
    expect_in(3, 6'b110111, 4'd0, "sel_high_r");
    tick(4);

    // A button change shows one cycle later.
    btn = 12'h030;
    expect_in(1, 6'b001111, 4'd0, "btn_c_b_high");
    tick(2);

    // Falling edge: the low map appears exactly three cycles later.
    sel_in = 1'b0;
    btn    = 12'h0C0;
    expect_in(1, 6'b111111, 4'd0, "a_start_high_map");
    expect_in(2, 6'b111111, 4'd0, "fall_latency_2");
    expect_in(3, 6'b000011, 4'd1, "fall_low_map");
    tick(5);

    sel_in = 1'b1;
    expect_in(3, 6'b111111, 4'd2, "rise_e2");
    tick(5);

    // Reset mid-sequence abandons the count.
    reset = 1'b1;
    expect_in(1, 6'b111111, 4'd0, "reset_mid_seq");
    tick(2);
    reset = 1'b0;
    btn   = seq_btn;
    tick(3);

    // Seven edges, 10 cycles apart, starting from high.
    for (int i = 1; i <= 7; i++) begin
      sel_in = ~sel_in;
      expect_in(2, seq_pad[i-1], 4'(i - 1), $sformatf("seq_pre_e%0d", i));
      expect_in(3, seq_pad[i],   4'(i),     $sformatf("seq_e%0d", i));
      tick(10);
    end

    // Edges 8 to 10: the counter saturates at 8 with the normal maps.
    sel_in = 1'b1;
    expect_in(3, 6'b111111, 4'd8, "sat_e8_high");
    tick(10);
    sel_in = 1'b0;
    expect_in(3, 6'b110011, 4'd8, "sat_e9_low");
    tick(10);
    sel_in = 1'b1;
    expect_in(3, 6'b111111, 4'd8, "sat_e10_high");
    // The counter updates at +3. It clears TIMEOUT_CYC-1 cycles after that.
    expect_in(T + 1, 6'b111111, 4'd8, "timeout_pre");
    expect_in(T + 2, 6'b111111, 4'd0, "timeout_clear");
    tick(T + 5);

    // The next falling edge counts from 0 and uses the normal low map.
    sel_in = 1'b0;
    expect_in(3, 6'b110011, 4'd1, "post_timeout_fall");
    tick(T - 1);

    // An edge that lands in the exact timeout cycle wins, and the timer
    // restarts.
    sel_in = 1'b1;
    expect_in(2,     6'b110011, 4'd1, "tmo_edge_pre");
    expect_in(3,     6'b111111, 4'd2, "tmo_edge_wins");
    expect_in(T + 1, 6'b111111, 4'd2, "timer_restart_hold");
    expect_in(T + 2, 6'b111111, 4'd0, "timer_restart_clear");
    tick(T + 5);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 50 && sb.size() > 0; k++) tick(1);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
